// File: rtl/i2c_pkg.sv
// Shared constants for the I2C SFR front end: SFR addresses, register bit
// positions and the transmit sequencer state encoding.
package i2c_pkg;

    // Default SFR addresses on the DW8051 SFR bus
    localparam logic [7:0] SFR_DATA_ADDR = 8'h9C;
    localparam logic [7:0] SFR_CTRL_ADDR = 8'h9A;
    localparam logic [7:0] SFR_STAT_ADDR = 8'h9B;

    // Control register bit positions
    localparam int CTRL_GO      = 0;
    localparam int CTRL_STOP_EN = 4;
    localparam int CTRL_FLUSH   = 7;

    // Status register bit positions
    localparam int STAT_BUSY    = 7;
    localparam int STAT_DONE    = 6;
    localparam int STAT_ACK_ERR = 5;
    localparam int STAT_OVF     = 4;
    localparam int STAT_FULL    = 3;
    localparam int STAT_EMPTY   = 2;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } txq_state_e;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output. Pushes into a
// full FIFO and pops from an empty FIFO are ignored; flush empties it.
module i2c_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Byte storage write port
    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/i2c_sfr_txq.sv
// SFR-bus front end and transmit queue for the I2C master bit engine.
// The CPU queues payload bytes through the data SFR and launches a
// transaction through the control SFR; the sequencer then streams the queued
// bytes to the engine over valid/ready and records the outcome in status.
module i2c_sfr_txq
    import i2c_pkg::*;
#(
    parameter logic [7:0] DATA_ADDR = SFR_DATA_ADDR,
    parameter logic [7:0] CTRL_ADDR = SFR_CTRL_ADDR,
    parameter logic [7:0] STAT_ADDR = SFR_STAT_ADDR,
    parameter int         DEPTH     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_wr,
    input  logic [7:0] I2C_data_in,
    output logic       I2C_sfr_cs,
    output logic [7:0] I2C_data_out,
    output logic       eng_start,
    output logic       eng_stop,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    input  logic       eng_ack_err,
    input  logic       eng_done
);

    localparam int CW = $clog2(DEPTH) + 1;

    txq_state_e    r_state;
    txq_state_e    w_state_next;
    logic          r_stop_en;
    logic          r_done;
    logic          r_ack_err;
    logic          r_ovf;

    logic          w_data_wr;
    logic          w_ctrl_wr;
    logic          w_flush_cmd;
    logic          w_go_cmd;
    logic          w_go_launch;
    logic          w_go_empty;
    logic          w_abort;
    logic          w_fifo_flush;
    logic          w_pop;
    logic          w_busy;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic [7:0]    w_status;

    // SFR decode: a GO is only accepted when idle and not overridden by FLUSH
    assign w_data_wr    = sfr_wr && (sfr_addr == DATA_ADDR);
    assign w_ctrl_wr    = sfr_wr && (sfr_addr == CTRL_ADDR);
    assign w_flush_cmd  = w_ctrl_wr && I2C_data_in[CTRL_FLUSH];
    assign w_go_cmd     = w_ctrl_wr && I2C_data_in[CTRL_GO] && !I2C_data_in[CTRL_FLUSH]
                          && (r_state == ST_IDLE);
    assign w_go_launch  = w_go_cmd && !w_empty;
    assign w_go_empty   = w_go_cmd && w_empty;
    assign w_abort      = eng_ack_err && ((r_state == ST_SEND) || (r_state == ST_WAIT));
    assign w_fifo_flush = w_flush_cmd || w_abort;
    assign w_pop        = tx_valid && tx_ready;
    assign w_busy       = (r_state != ST_IDLE);

    assign w_status = {w_busy, r_done, r_ack_err, r_ovf, w_full, w_empty, w_count[1:0]};

    assign I2C_sfr_cs   = (sfr_addr == DATA_ADDR) || (sfr_addr == CTRL_ADDR)
                          || (sfr_addr == STAT_ADDR);
    assign I2C_data_out = (sfr_addr == STAT_ADDR) ? w_status : 8'h00;
    assign tx_data      = w_head;

    i2c_byte_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_data_wr),
        .i_data  (I2C_data_in),
        .i_pop   (w_pop),
        .i_flush (w_fifo_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next state and engine-side outputs
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        eng_start    = 1'b0;
        eng_stop     = 1'b0;
        tx_valid     = 1'b0;
        tx_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go_launch) w_state_next = ST_START;
            end
            ST_START: begin
                eng_start    = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = !w_empty;
                // A byte pushed in the same clk extends the transaction
                tx_last  = (w_count == CW'(1)) && !w_data_wr;
                eng_stop = r_stop_en;
                if (w_abort) begin
                    w_state_next = ST_WAIT;
                end else if (tx_valid && tx_ready && tx_last) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latched STOP_EN and sticky status flags; a set in the same clk as a
    // clear wins so no event is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop_en <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_go_launch) r_stop_en <= I2C_data_in[CTRL_STOP_EN];

            if (w_flush_cmd || w_go_cmd) begin
                r_done    <= 1'b0;
                r_ack_err <= 1'b0;
                r_ovf     <= 1'b0;
            end
            if (w_go_empty || ((r_state == ST_WAIT) && eng_done)) r_done <= 1'b1;
            if (w_abort) r_ack_err <= 1'b1;
            if (w_data_wr && w_full) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_sfr_txq.sv
// Directed self-checking bench for i2c_sfr_txq: queue, launch, stream,
// stall, overflow, flush, NACK abort, empty GO, and mid-transaction reset.
module tb_i2c_sfr_txq;

    logic       clk;
    logic       rst_n;
    logic [7:0] sfr_addr;
    logic       sfr_wr;
    logic [7:0] I2C_data_in;
    logic       I2C_sfr_cs;
    logic [7:0] I2C_data_out;
    logic       eng_start;
    logic       eng_stop;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       eng_ack_err;
    logic       eng_done;

    int         n_checks;
    int         n_pass;
    logic [7:0] exp_q [16];
    logic [7:0] stat;

    i2c_sfr_txq #(
        .DEPTH        (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sfr_addr     (sfr_addr),
        .sfr_wr       (sfr_wr),
        .I2C_data_in  (I2C_data_in),
        .I2C_sfr_cs   (I2C_sfr_cs),
        .I2C_data_out (I2C_data_out),
        .eng_start    (eng_start),
        .eng_stop     (eng_stop),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .eng_ack_err  (eng_ack_err),
        .eng_done     (eng_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One SFR write strobe; returns #1 after the negedge following the write edge
    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        sfr_addr    = addr;
        I2C_data_in = data;
        sfr_wr      = 1'b1;
        @(negedge clk);
        sfr_wr      = 1'b0;
        sfr_addr    = 8'h00;
        I2C_data_in = 8'h00;
        #1;
    endtask

    // Combinational status read, no clock consumed
    task automatic stat_read(output logic [7:0] v);
        sfr_addr = 8'h9B;
        #1;
        v        = I2C_data_out;
        sfr_addr = 8'h00;
    endtask

    // Take n bytes from the engine port; tx_last expected on index n_tot-1;
    // optionally hold tx_ready low stall_len clks on byte stall_idx
    task automatic recv(input int n, input int n_tot, input int stall_idx,
                        input int stall_len, input logic exp_stop);
        int idx;
        int stall;
        int starts;
        idx    = 0;
        stall  = 0;
        starts = 0;
        for (int cyc = 0; cyc < 200 && idx < n; cyc++) begin
            @(negedge clk);
            #1;
            if (eng_start) starts++;
            if (idx == stall_idx && stall < stall_len) begin
                tx_ready = 1'b0;
                check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp_q[idx]});
                stall++;
            end else if (tx_valid) begin
                check("tx_data", tx_data, exp_q[idx]);
                check("tx_last", tx_last, (idx == n_tot - 1));
                check("eng_stop", eng_stop, exp_stop);
                tx_ready = 1'b1;
                idx++;
            end else begin
                tx_ready = 1'b0;
            end
        end
        check("recv_count", idx, n);
        check("no_restart", starts, 0);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
    endtask

    task automatic done_pulse();
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        sfr_addr    = 8'h00;
        sfr_wr      = 1'b0;
        I2C_data_in = 8'h00;
        tx_ready    = 1'b0;
        eng_ack_err = 1'b0;
        eng_done    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state and decode
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_tx_last", tx_last, 1'b0);
        check("unsel_data_out", I2C_data_out, 8'h00);
        check("unsel_cs", I2C_sfr_cs, 1'b0);
        stat_read(stat);
        check("rst_stat", stat, 8'h04);
        sfr_addr = 8'h9A; #1; check("cs_ctrl", I2C_sfr_cs, 1'b1);
        sfr_addr = 8'h9C; #1; check("cs_data", I2C_sfr_cs, 1'b1);
        check("data_rd_zero", I2C_data_out, 8'h00);
        sfr_addr = 8'h9D; #1; check("cs_miss", I2C_sfr_cs, 1'b0);
        sfr_write(8'h9B, 8'hFF);
        stat_read(stat);
        check("stat_wr_ignored", stat, 8'h04);

        // 1: basic transaction with STOP
        exp_q[0] = 8'hA0; exp_q[1] = 8'h00; exp_q[2] = 8'h00; exp_q[3] = 8'h12;
        for (int i = 0; i < 4; i++) sfr_write(8'h9C, exp_q[i]);
        stat_read(stat);
        check("t1_stat_queued", stat, 8'h00);
        sfr_write(8'h9A, 8'h11);
        check("t1_eng_start", eng_start, 1'b1);
        check("t1_valid_in_start", tx_valid, 1'b0);
        recv(4, 4, -1, 0, 1'b1);
        check("t1_wait_no_valid", tx_valid, 1'b0);
        done_pulse();
        stat_read(stat);
        check("t1_stat_done", stat, 8'h44);

        // 2: stall on the second byte
        exp_q[0] = 8'h5A; exp_q[1] = 8'h00; exp_q[2] = 8'h3C;
        for (int i = 0; i < 3; i++) sfr_write(8'h9C, exp_q[i]);
        sfr_write(8'h9A, 8'h11);
        check("t2_eng_start", eng_start, 1'b1);
        recv(3, 3, 1, 20, 1'b1);
        check("t2_wait_no_valid", tx_valid, 1'b0);
        done_pulse();
        stat_read(stat);
        check("t2_stat_done", stat, 8'h44);

        // 3: overflow drops the extra byte; GO and FLUSH clear ovf
        for (int i = 0; i < 8; i++) sfr_write(8'h9C, 8'h50 + 8'(i));
        stat_read(stat);
        check("t3_stat_full", stat, 8'h48);
        sfr_write(8'h9C, 8'hEE);
        stat_read(stat);
        check("t3_stat_ovf", stat, 8'h58);
        for (int i = 0; i < 8; i++) exp_q[i] = 8'h50 + 8'(i);
        sfr_write(8'h9A, 8'h11);
        recv(8, 8, -1, 0, 1'b1);
        done_pulse();
        stat_read(stat);
        check("t3_stat_after_go", stat, 8'h44);
        for (int i = 0; i < 9; i++) sfr_write(8'h9C, 8'h60 + 8'(i));
        stat_read(stat);
        check("t3_stat_ovf2", stat, 8'h58);
        sfr_write(8'h9A, 8'h80);
        stat_read(stat);
        check("t3_stat_flush", stat, 8'h04);

        // 4: NACK after byte 2, GO while busy ignored
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04;
        for (int i = 0; i < 4; i++) sfr_write(8'h9C, exp_q[i]);
        sfr_write(8'h9A, 8'h11);
        stat_read(stat);
        check("t4_stat_busy", stat, 8'h80);
        recv(2, 4, -1, 0, 1'b1);
        eng_ack_err = 1'b1;
        @(negedge clk);
        eng_ack_err = 1'b0;
        #1;
        check("t4_abort_no_valid", tx_valid, 1'b0);
        stat_read(stat);
        check("t4_stat_ackerr", stat, 8'hA4);
        sfr_write(8'h9A, 8'h11);
        check("t4_busy_go_no_start", eng_start, 1'b0);
        stat_read(stat);
        check("t4_stat_busy_go", stat, 8'hA4);
        done_pulse();
        stat_read(stat);
        check("t4_stat_done", stat, 8'h64);

        // 5: GO with empty FIFO, then a hold-bus transaction (STOP_EN=0)
        sfr_write(8'h9A, 8'h11);
        check("t5_empty_no_start", eng_start, 1'b0);
        stat_read(stat);
        check("t5_stat_empty_go", stat, 8'h44);
        begin
            int starts;
            starts = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1;
                if (eng_start) starts++;
            end
            check("t5_empty_no_start_later", starts, 0);
        end
        exp_q[0] = 8'hAA; exp_q[1] = 8'hBB;
        for (int i = 0; i < 2; i++) sfr_write(8'h9C, exp_q[i]);
        sfr_write(8'h9A, 8'h01);
        check("t5_eng_start", eng_start, 1'b1);
        recv(2, 2, -1, 0, 1'b0);
        done_pulse();
        stat_read(stat);
        check("t5_stat_done", stat, 8'h44);

        // 6: reset in the middle of SEND
        for (int i = 0; i < 3; i++) sfr_write(8'h9C, 8'hC1 + 8'(i));
        sfr_write(8'h9A, 8'h11);
        @(negedge clk);
        #1;
        check("t6_send_valid", tx_valid, 1'b1);
        stat_read(stat);
        check("t6_stat_send", stat, 8'h83);
        rst_n = 1'b0;
        #1;
        check("t6_rst_no_valid", tx_valid, 1'b0);
        stat_read(stat);
        check("t6_rst_stat", stat, 8'h04);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        stat_read(stat);
        check("t6_post_rst_stat", stat, 8'h04);
        check("t6_post_rst_valid", tx_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
